seg_scan_disp: RTL and testbench

//   Parametrised time-multiplexed 7-segment scanner for N common-node digits.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/blink_gen.sv | 33 +++
 rtl/seg_scan_disp.sv | 190 +++++++++++++++++++
 tb/tb_seg_scan_disp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner family:
// scan-phase encodings, the blank segment code and the digit-enable polarity helper.
package seg_pkg;

   typedef enum logic [0:0] {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } scan_state_t;

   localparam int PWM_W = 4;

   localparam logic [31:0] SEG_OFF = 32'h0000_0000;

   // Maps a logical "digit on" request to the pin level for the board's enable polarity.
   function automatic logic enb_drive(input logic active_low, input logic on);
      logic level;
      if (active_low) begin
         level = ~on;
      end else begin
         level = on;
      end
      return level;
   endfunction

endpackage

// File: rtl/blink_gen.sv
// Free-running blink phase generator: blink_vis is high for the first half of
// every BLINK_DIV-cycle period and low for the second half.
module blink_gen #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic rst,
   output logic blink_vis
);

   localparam int HALF  = BLINK_DIV / 2;
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HALF > 0) ? (HALF - 1) : 0);

   logic [CNT_W-1:0] blink_cnt_r;
   logic             blink_vis_r;

   // Half-period counter; the visible phase flips each time it wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_r <= '0;
         blink_vis_r <= 1'b1;
      end else if (blink_cnt_r == CNT_LAST) begin
         blink_cnt_r <= '0;
         blink_vis_r <= ~blink_vis_r;
      end else begin
         blink_cnt_r <= blink_cnt_r + CNT_W'(1);
      end
   end

   assign blink_vis = blink_vis_r;

endmodule

// File: rtl/seg_scan_disp.sv
// Time-multiplexed N-digit 7-segment scanner with ghost-suppression blanking,
// 16-level PWM brightness and per-digit blink; every pin is driven from a register.
module seg_scan_disp
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int SEG_W          = 7,
   parameter int SCAN_DIV       = 5000,
   parameter int BLANK_CYC      = 64,
   parameter int BLINK_DIV      = 25000000,
   parameter int ENB_ACTIVE_LOW = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_DIGITS*SEG_W-1:0]   i_digit_seg,
   input  logic [NUM_DIGITS-1:0]         i_dp,
   input  logic [NUM_DIGITS-1:0]         i_blink_mask,
   input  logic [3:0]                    i_bright,
   output logic [SEG_W-1:0]              o_seg,
   output logic                          o_seg_dp,
   output logic [NUM_DIGITS-1:0]         o_seg_enb,
   output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx,
   output logic                          o_frame_start
);

   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'((BLANK_CYC == 0) ? 0 : (BLANK_CYC - 1));
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam scan_state_t       STATE_RST  = (BLANK_CYC == 0) ? S_ON : S_BLANK;
   localparam logic [NUM_DIGITS-1:0] ENB_OFF = {NUM_DIGITS{(ENB_ACTIVE_LOW != 0) ? 1'b1 : 1'b0}};

   logic [SLOT_W-1:0]     slot_cnt_r;
   logic [IDX_W-1:0]      digit_idx_r;
   logic                  first_slot_r;
   scan_state_t           state_r;
   scan_state_t           state_nxt_s;
   logic [PWM_W-1:0]      pwm_cnt_r;
   logic [PWM_W-1:0]      pwm_nxt_s;
   logic [SEG_W-1:0]      sh_seg_r;
   logic                  sh_dp_r;
   logic                  sh_mask_r;
   logic [SEG_W-1:0]      live_seg_s;
   logic                  live_dp_s;
   logic                  live_mask_s;
   logic [SEG_W-1:0]      cur_seg_s;
   logic                  cur_dp_s;
   logic                  cur_mask_s;
   logic                  blink_vis_s;
   logic                  en_s;
   logic                  show_s;
   logic [NUM_DIGITS-1:0] onehot_s;
   logic [NUM_DIGITS-1:0] enb_nxt_s;
   logic [SEG_W-1:0]      seg_nxt_s;
   logic                  dp_nxt_s;
   logic                  frame_nxt_s;

   blink_gen #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink_gen (
      .clk       (clk),
      .rst       (rst),
      .blink_vis (blink_vis_s)
   );

   // Slot timer and digit pointer; first_slot_r suppresses the frame pulse right after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt_r   <= '0;
         digit_idx_r  <= '0;
         first_slot_r <= 1'b1;
      end else if (slot_cnt_r == SLOT_LAST) begin
         slot_cnt_r   <= '0;
         first_slot_r <= 1'b0;
         if (digit_idx_r == IDX_LAST) begin
            digit_idx_r <= '0;
         end else begin
            digit_idx_r <= digit_idx_r + IDX_W'(1);
         end
      end else begin
         slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
      end
   end

   // Slice of the digit currently addressed, straight from the input bus.
   always_comb begin
      live_seg_s  = i_digit_seg[digit_idx_r*SEG_W +: SEG_W];
      live_dp_s   = i_dp[digit_idx_r];
      live_mask_s = i_blink_mask[digit_idx_r];
   end

   // Shadow copy taken on the first cycle of each slot so mid-slot input edits never tear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_seg_r  <= SEG_OFF[SEG_W-1:0];
         sh_dp_r   <= 1'b0;
         sh_mask_r <= 1'b0;
      end else if (slot_cnt_r == '0) begin
         sh_seg_r  <= live_seg_s;
         sh_dp_r   <= live_dp_s;
         sh_mask_r <= live_mask_s;
      end else begin
         sh_seg_r  <= sh_seg_r;
         sh_dp_r   <= sh_dp_r;
         sh_mask_r <= sh_mask_r;
      end
   end

   // Scan phase and PWM counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= STATE_RST;
         pwm_cnt_r <= '0;
      end else begin
         state_r   <= state_nxt_s;
         pwm_cnt_r <= pwm_nxt_s;
      end
   end

   // Blank/on sequencing within a slot; PWM restarts from 0 at the start of every on phase.
   always_comb begin
      state_nxt_s = state_r;
      pwm_nxt_s   = pwm_cnt_r;
      case (state_r)
         S_BLANK: begin
            pwm_nxt_s = '0;
            if (slot_cnt_r == BLANK_LAST) begin
               state_nxt_s = S_ON;
            end else begin
               state_nxt_s = S_BLANK;
            end
         end
         S_ON: begin
            if (slot_cnt_r == SLOT_LAST) begin
               state_nxt_s = (BLANK_CYC == 0) ? S_ON : S_BLANK;
               pwm_nxt_s   = '0;
            end else begin
               state_nxt_s = S_ON;
               pwm_nxt_s   = pwm_cnt_r + PWM_W'(1);
            end
         end
         default: begin
            state_nxt_s = STATE_RST;
            pwm_nxt_s   = '0;
         end
      endcase
   end

   // Next pin values. On slot_cnt 0 the shadow is still being loaded, so the live slice
   // stands in (only reachable as an on cycle when there is no blank phase).
   always_comb begin
      if (slot_cnt_r == '0) begin
         cur_seg_s  = live_seg_s;
         cur_dp_s   = live_dp_s;
         cur_mask_s = live_mask_s;
      end else begin
         cur_seg_s  = sh_seg_r;
         cur_dp_s   = sh_dp_r;
         cur_mask_s = sh_mask_r;
      end
      en_s     = (state_r == S_ON) && (pwm_cnt_r <= i_bright);
      show_s   = en_s && !(cur_mask_s && !blink_vis_s);
      onehot_s = en_s ? (NUM_DIGITS'(1) << digit_idx_r) : '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         enb_nxt_s[k] = enb_drive(ENB_ACTIVE_LOW != 0, onehot_s[k]);
      end
      seg_nxt_s   = show_s ? cur_seg_s : SEG_OFF[SEG_W-1:0];
      dp_nxt_s    = show_s ? cur_dp_s : 1'b0;
      frame_nxt_s = (slot_cnt_r == '0) && (digit_idx_r == '0) && !first_slot_r;
   end

   // Output register stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_seg_enb     <= ENB_OFF;
         o_seg         <= SEG_OFF[SEG_W-1:0];
         o_seg_dp      <= 1'b0;
         o_digit_idx   <= '0;
         o_frame_start <= 1'b0;
      end else begin
         o_seg_enb     <= enb_nxt_s;
         o_seg         <= seg_nxt_s;
         o_seg_dp      <= dp_nxt_s;
         o_digit_idx   <= digit_idx_r;
         o_frame_start <= frame_nxt_s;
      end
   end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Directed bench for seg_scan_disp at NUM_DIGITS=4, SCAN_DIV=20, BLANK_CYC=4, BLINK_DIV=200.
module tb_seg_scan_disp;

   logic        clk = 1'b0;
   logic        rst;
   logic [27:0] i_digit_seg;
   logic [3:0]  i_dp;
   logic [3:0]  i_blink_mask;
   logic [3:0]  i_bright;
   logic [6:0]  o_seg;
   logic        o_seg_dp;
   logic [3:0]  o_seg_enb;
   logic [1:0]  o_digit_idx;
   logic        o_frame_start;

   int checks = 0;
   int errors = 0;
   int c = 0;

   logic [6:0] sh_seg;
   logic       sh_dp;
   logic       sh_mask;
   logic [3:0] e_enb;
   logic [6:0] e_seg;
   logic       e_dp;
   logic [1:0] e_idx;
   logic       e_fs;

   seg_scan_disp #(
      .NUM_DIGITS     (4),
      .SEG_W          (7),
      .SCAN_DIV       (20),
      .BLANK_CYC      (4),
      .BLINK_DIV      (200),
      .ENB_ACTIVE_LOW (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_digit_seg   (i_digit_seg),
      .i_dp          (i_dp),
      .i_blink_mask  (i_blink_mask),
      .i_bright      (i_bright),
      .o_seg         (o_seg),
      .o_seg_dp      (o_seg_dp),
      .o_seg_enb     (o_seg_enb),
      .o_digit_idx   (o_digit_idx),
      .o_frame_start (o_frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Expected pins for scan cycle c (counted from reset release), then one clock.
   task automatic advance();
      int   slot, dig, pwm;
      logic vis, en;
      slot = c % 20;
      dig  = (c / 20) % 4;
      vis  = ((c / 100) % 2) == 0;
      if (slot == 0) begin
         sh_seg  = i_digit_seg[dig*7 +: 7];
         sh_dp   = i_dp[dig];
         sh_mask = i_blink_mask[dig];
      end
      en = 1'b0;
      if (slot >= 4) begin
         pwm = slot - 4;
         en  = (pwm <= int'(i_bright));
      end
      e_enb = en ? ~(4'b0001 << dig) : 4'b1111;
      e_seg = (en && !(sh_mask && !vis)) ? sh_seg : 7'h00;
      e_dp  = (en && !(sh_mask && !vis)) ? sh_dp : 1'b0;
      e_idx = 2'(dig);
      e_fs  = (slot == 0) && (dig == 0) && (c != 0);
      @(posedge clk);
      #1;
      c++;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      i_digit_seg  = {7'h79, 7'h6D, 7'h30, 7'h7E};
      i_dp         = 4'b0000;
      i_blink_mask = 4'b0000;
      i_bright     = 4'd15;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (o_seg_enb !== 4'b1111) begin errors++; $display("FAIL reset_enb got %b want 1111", o_seg_enb); end
      checks++; if (o_seg !== 7'h00) begin errors++; $display("FAIL reset_seg got %h want 00", o_seg); end
      checks++; if (o_seg_dp !== 1'b0) begin errors++; $display("FAIL reset_dp got %b want 0", o_seg_dp); end
      checks++; if (o_digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", o_digit_idx); end
      checks++; if (o_frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", o_frame_start); end
      @(negedge clk);
      rst = 1'b0;
      c   = 0;
   endtask

   task automatic test_scan();
      int frames = 0;
      i_bright = 4'd15;
      repeat (100) begin
         advance();
         checks++; if (o_seg_enb !== e_enb) begin errors++; $display("FAIL scan_enb c=%0d got %b want %b", c-1, o_seg_enb, e_enb); end
         checks++; if (o_seg !== e_seg) begin errors++; $display("FAIL scan_seg c=%0d got %h want %h", c-1, o_seg, e_seg); end
         checks++; if (o_digit_idx !== e_idx) begin errors++; $display("FAIL scan_idx c=%0d got %0d want %0d", c-1, o_digit_idx, e_idx); end
         checks++; if (o_frame_start !== e_fs) begin errors++; $display("FAIL scan_fs c=%0d got %b want %b", c-1, o_frame_start, e_fs); end
         if (o_frame_start === 1'b1) frames++;
         if (c - 1 == 46) begin
            checks++; if (o_seg !== 7'h6D || o_seg_enb !== 4'b1011) begin errors++; $display("FAIL scan_digit2 got %h/%b want 6d/1011", o_seg, o_seg_enb); end
         end
      end
      checks++; if (frames !== 1) begin errors++; $display("FAIL scan_frame_count got %0d want 1", frames); end
   endtask

   task automatic test_pwm();
      int act;
      i_bright = 4'd3;
      for (int s = 0; s < 4; s++) begin
         act = 0;
         repeat (20) begin
            advance();
            checks++; if (o_seg_enb !== e_enb) begin errors++; $display("FAIL pwm_enb c=%0d got %b want %b", c-1, o_seg_enb, e_enb); end
            checks++; if (o_seg !== e_seg) begin errors++; $display("FAIL pwm_seg c=%0d got %h want %h", c-1, o_seg, e_seg); end
            if (o_seg_enb !== 4'b1111) act++;
         end
         checks++; if (act !== 4) begin errors++; $display("FAIL pwm_active slot=%0d got %0d want 4", s, act); end
      end
      i_bright = 4'd15;
   endtask

   task automatic test_blink();
      int d1_vis = 0;
      int d1_dark = 0;
      i_blink_mask = 4'b0010;
      repeat (200) begin
         advance();
         checks++; if (o_seg_enb !== e_enb) begin errors++; $display("FAIL blink_enb c=%0d got %b want %b", c-1, o_seg_enb, e_enb); end
         checks++; if (o_seg !== e_seg) begin errors++; $display("FAIL blink_seg c=%0d got %h want %h", c-1, o_seg, e_seg); end
         if (o_seg_enb === 4'b1101 && o_seg === 7'h30) d1_vis++;
         if (o_seg_enb === 4'b1101 && o_seg === 7'h00) d1_dark++;
      end
      checks++; if (d1_vis !== 16) begin errors++; $display("FAIL blink_visible got %0d want 16", d1_vis); end
      checks++; if (d1_dark !== 32) begin errors++; $display("FAIL blink_dark got %0d want 32", d1_dark); end
      i_blink_mask = 4'b0000;
   endtask

   task automatic test_shadow();
      int guard = 0;
      while (!((c % 20 == 10) && ((c / 20) % 4 == 1)) && guard < 200) begin
         advance();
         guard++;
         checks++; if (o_seg !== e_seg) begin errors++; $display("FAIL shadow_pre_seg c=%0d got %h want %h", c-1, o_seg, e_seg); end
      end
      checks++; if (guard >= 200) begin errors++; $display("FAIL shadow_seek got %0d want <200", guard); end
      i_digit_seg[13:7] = 7'h5B;
      repeat (90) begin
         advance();
         checks++; if (o_seg !== e_seg) begin errors++; $display("FAIL shadow_seg c=%0d got %h want %h", c-1, o_seg, e_seg); end
         if (c - 1 == 435) begin
            checks++; if (o_seg !== 7'h30) begin errors++; $display("FAIL shadow_hold got %h want 30", o_seg); end
         end
         if (c - 1 == 505) begin
            checks++; if (o_seg !== 7'h5B) begin errors++; $display("FAIL shadow_new got %h want 5b", o_seg); end
         end
      end
   endtask

   task automatic test_dp();
      int dp_hi = 0;
      i_dp = 4'b0101;
      repeat (80) begin
         advance();
         checks++; if (o_seg_dp !== e_dp) begin errors++; $display("FAIL dp c=%0d got %b want %b", c-1, o_seg_dp, e_dp); end
         if (o_seg_enb === 4'b1111) begin
            checks++; if (o_seg_dp !== 1'b0) begin errors++; $display("FAIL dp_blank c=%0d got %b want 0", c-1, o_seg_dp); end
         end
         if (o_seg_dp === 1'b1) dp_hi++;
      end
      checks++; if (dp_hi !== 32) begin errors++; $display("FAIL dp_count got %0d want 32", dp_hi); end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      while (!((c % 20 == 12) && ((c / 20) % 4 == 2)) && guard < 100) begin
         advance();
         guard++;
      end
      checks++; if (o_seg_enb !== 4'b1011) begin errors++; $display("FAIL mid_pre_enb got %b want 1011", o_seg_enb); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (o_seg_enb !== 4'b1111) begin errors++; $display("FAIL mid_enb got %b want 1111", o_seg_enb); end
      checks++; if (o_seg !== 7'h00) begin errors++; $display("FAIL mid_seg got %h want 00", o_seg); end
      checks++; if (o_digit_idx !== 2'd0) begin errors++; $display("FAIL mid_idx got %0d want 0", o_digit_idx); end
      @(negedge clk);
      rst = 1'b0;
      c   = 0;
      repeat (24) begin
         advance();
         checks++; if (o_seg_enb !== e_enb) begin errors++; $display("FAIL mid_post_enb c=%0d got %b want %b", c-1, o_seg_enb, e_enb); end
         checks++; if (o_seg !== e_seg) begin errors++; $display("FAIL mid_post_seg c=%0d got %h want %h", c-1, o_seg, e_seg); end
         checks++; if (o_digit_idx !== e_idx) begin errors++; $display("FAIL mid_post_idx c=%0d got %0d want %0d", c-1, o_digit_idx, e_idx); end
         checks++; if (o_frame_start !== e_fs) begin errors++; $display("FAIL mid_post_fs c=%0d got %b want %b", c-1, o_frame_start, e_fs); end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_pwm();
      test_blink();
      test_shadow();
      test_dp();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
